// File: rtl/stack_arbiter.sv
// stack_arbiter
//   Shares one registered-output hardware LIFO between the core (port 0) and
//   the interrupt unit (port 1). Grants at most one request per cycle with
//   round-robin tie breaking. It tracks occupancy so the stack is never pushed
//   when full or popped when empty. Pops are sequenced through a response
//   cycle (RESP) because the stack presents popped data one edge later. The
//   block keeps sticky overflow/underflow flags and can flush the stack.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/pop/data/ready  request channel per port (pop=0 push, pop=1 pop)
//   rspN_valid/data/err        one-cycle pop response per port (err = underflow)
//   flush                      empty the stack (highest priority)
//   clr_err                    clear sticky error flags
//   stk_reset/push/pop/data    controls to the stack
//   stk_out                    registered stack output
//   count, full, empty         occupancy status
//   err_overflow/underflow     sticky error flags
module stack_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_pop,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_pop,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  input  logic             flush,
  input  logic             clr_err,
  output logic             stk_reset,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data,
  input  logic [WIDTH-1:0] stk_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err_overflow,
  output logic             err_underflow
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic             prio_r;       // port that wins when both are valid
  logic             resp_port_r;  // requester owed the pending response
  logic             resp_uf_r;    // pending response is an underflow
  logic             ovf_r;
  logic             udf_r;

  logic             grant_s;
  logic             grant_port_s;
  logic             sel_pop_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             ovf_evt_s;
  logic             udf_evt_s;
  logic             resp_act_s;

  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == {CNT_W{1'b0}});

  // Arbitration: pick one valid requester in IDLE unless reset/flush blocks it.
  always_comb begin
    grant_s      = 1'b0;
    grant_port_s = 1'b0;
    if ((state_r == IDLE) && !reset && !flush) begin
      if (req0_valid && req1_valid) begin
        grant_s      = 1'b1;
        grant_port_s = prio_r;
      end else if (req0_valid) begin
        grant_s      = 1'b1;
        grant_port_s = 1'b0;
      end else if (req1_valid) begin
        grant_s      = 1'b1;
        grant_port_s = 1'b1;
      end else begin
        grant_s      = 1'b0;
        grant_port_s = 1'b0;
      end
    end else begin
      grant_s      = 1'b0;
      grant_port_s = 1'b0;
    end
  end

  // Request mux and classification of the granted operation.
  always_comb begin
    sel_pop_s  = 1'b0;
    sel_data_s = {WIDTH{1'b0}};
    if (grant_port_s) begin
      sel_pop_s  = req1_pop;
      sel_data_s = req1_data;
    end else begin
      sel_pop_s  = req0_pop;
      sel_data_s = req0_data;
    end
    push_ok_s = grant_s && !sel_pop_s && !full_s;
    ovf_evt_s = grant_s && !sel_pop_s && full_s;
    pop_ok_s  = grant_s && sel_pop_s && !empty_s;
    udf_evt_s = grant_s && sel_pop_s && empty_s;
  end

  // Next-state: any accepted pop (good or underflow) spends one cycle in RESP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s && sel_pop_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode. Reset suppresses a response still pending in RESP.
  always_comb begin
    resp_act_s    = (state_r == RESP) && !reset;
    req0_ready    = grant_s && !grant_port_s;
    req1_ready    = grant_s && grant_port_s;
    stk_reset     = reset || flush;
    stk_push      = push_ok_s;
    stk_pop       = pop_ok_s;
    stk_data      = push_ok_s ? sel_data_s : {WIDTH{1'b0}};
    rsp0_valid    = resp_act_s && !resp_port_r;
    rsp1_valid    = resp_act_s && resp_port_r;
    rsp0_err      = rsp0_valid && resp_uf_r;
    rsp1_err      = rsp1_valid && resp_uf_r;
    rsp0_data     = (rsp0_valid && !resp_uf_r) ? stk_out : {WIDTH{1'b0}};
    rsp1_data     = (rsp1_valid && !resp_uf_r) ? stk_out : {WIDTH{1'b0}};
    count         = count_r;
    full          = full_s;
    empty         = empty_s;
    err_overflow  = ovf_r;
    err_underflow = udf_r;
  end

  // State, occupancy, round-robin pointer, response record and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      count_r     <= {CNT_W{1'b0}};
      prio_r      <= 1'b0;
      resp_port_r <= 1'b0;
      resp_uf_r   <= 1'b0;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;

      if (flush) begin
        count_r <= {CNT_W{1'b0}};
      end else if (push_ok_s) begin
        count_r <= count_r + ONE_C;
      end else if (pop_ok_s) begin
        count_r <= count_r - ONE_C;
      end else begin
        count_r <= count_r;
      end

      // Errored requests still count as grants for fairness.
      if (grant_s) begin
        prio_r <= !grant_port_s;
      end else begin
        prio_r <= prio_r;
      end

      if (grant_s && sel_pop_s) begin
        resp_port_r <= grant_port_s;
        resp_uf_r   <= empty_s;
      end else begin
        resp_port_r <= resp_port_r;
        resp_uf_r   <= resp_uf_r;
      end

      // A new error in the same cycle as clr_err keeps the flag set.
      if (ovf_evt_s) begin
        ovf_r <= 1'b1;
      end else if (clr_err) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end

      if (udf_evt_s) begin
        udf_r <= 1'b1;
      end else if (clr_err) begin
        udf_r <= 1'b0;
      end else begin
        udf_r <= udf_r;
      end
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;
  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int CNT_W = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req0_pop = 1'b0, req1_valid = 1'b0, req1_pop = 1'b0;
  logic [WIDTH-1:0] req0_data = 16'h0, req1_data = 16'h0;
  logic req0_ready, req1_ready;
  logic rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  logic flush = 1'b0, clr_err = 1'b0;
  logic stk_reset, stk_push, stk_pop;
  logic [WIDTH-1:0] stk_data;
  logic [WIDTH-1:0] stk_out;
  logic [CNT_W-1:0] count;
  logic full, empty, err_overflow, err_underflow;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_pop(req0_pop), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_pop(req1_pop), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .flush(flush), .clr_err(clr_err),
    .stk_reset(stk_reset), .stk_push(stk_push), .stk_pop(stk_pop), .stk_data(stk_data),
    .stk_out(stk_out), .count(count), .full(full), .empty(empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  // Behavioural LIFO with a registered output, driven only by the DUT.
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  int sp = 0;
  always @(posedge clk) begin
    if (stk_reset) begin
      sp      <= 0;
      stk_out <= 16'h0;
    end else if (stk_push) begin
      if (sp < DEPTH) begin
        mem[sp] <= stk_data;
        sp      <= sp + 1;
      end
    end else if (stk_pop) begin
      if (sp > 0) begin
        stk_out <= mem[sp-1];
        sp      <= sp - 1;
      end else begin
        stk_out <= 16'hDEAD;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue holds the stack contents; a pending-response record
  // describes what the next cycle owes; m_last is the port granted last.
  logic [WIDTH-1:0] q[$];
  int  m_last = 1;
  bit  m_resp = 1'b0, m_rport = 1'b0, m_rerr = 1'b0;
  logic [WIDTH-1:0] m_rdata = 16'h0;
  bit  m_ovf = 1'b0, m_udf = 1'b0;
  bit  acc0 = 1'b0, acc1 = 1'b0;

  always @(negedge clk) begin
    int g;
    bit gpop, e_push, e_pop, e_v0, e_v1, ovf_set, udf_set;
    logic [WIDTH-1:0] gdata;
    g = -1;
    if (!reset && !flush && !m_resp) begin
      if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
    end
    gpop   = (g == 1) ? req1_pop : req0_pop;
    gdata  = (g == 1) ? req1_data : req0_data;
    e_push = (g >= 0) && !gpop && (q.size() < DEPTH);
    e_pop  = (g >= 0) && gpop && (q.size() > 0);
    e_v0   = m_resp && !reset && !m_rport;
    e_v1   = m_resp && !reset && m_rport;
    acc0   = (g == 0);
    acc1   = (g == 1);
    if (check_en) begin
      chk("req0_ready", req0_ready, (g == 0));
      chk("req1_ready", req1_ready, (g == 1));
      chk("stk_push", stk_push, e_push);
      chk("stk_pop", stk_pop, e_pop);
      chk("stk_data", stk_data, e_push ? gdata : 16'h0);
      chk("stk_reset", stk_reset, reset || flush);
      chk("rsp0_valid", rsp0_valid, e_v0);
      chk("rsp1_valid", rsp1_valid, e_v1);
      chk("rsp0_data", rsp0_data, (e_v0 && !m_rerr) ? m_rdata : 16'h0);
      chk("rsp1_data", rsp1_data, (e_v1 && !m_rerr) ? m_rdata : 16'h0);
      chk("rsp0_err", rsp0_err, e_v0 && m_rerr);
      chk("rsp1_err", rsp1_err, e_v1 && m_rerr);
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_underflow", err_underflow, m_udf);
    end
    // Advance the model to the state after the coming rising edge.
    if (reset) begin
      q.delete();
      m_last = 1; m_resp = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      ovf_set = 1'b0; udf_set = 1'b0;
      m_resp  = 1'b0;
      if (flush) q.delete();
      if (g >= 0) begin
        m_last = g;
        if (gpop) begin
          m_resp  = 1'b1;
          m_rport = (g == 1);
          if (q.size() > 0) begin
            m_rdata = q.pop_back();
            m_rerr  = 1'b0;
          end else begin
            m_rdata = 16'h0;
            m_rerr  = 1'b1;
            udf_set = 1'b1;
          end
        end else if (q.size() < DEPTH) begin
          q.push_back(gdata);
        end else begin
          ovf_set = 1'b1;
        end
      end
      if (ovf_set) m_ovf = 1'b1; else if (clr_err) m_ovf = 1'b0;
      if (udf_set) m_udf = 1'b1; else if (clr_err) m_udf = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit v, input bit pop, input logic [WIDTH-1:0] d);
    if (p == 0) begin
      req0_valid = v; req0_pop = pop; req0_data = d;
    end else begin
      req1_valid = v; req1_pop = pop; req1_data = d;
    end
  endtask

  // Issue one request and hold it until accepted (bounded wait).
  task automatic req(input int p, input bit pop, input logic [WIDTH-1:0] d);
    bit done;
    done = 1'b0;
    set_req(p, 1'b1, pop, d);
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) done = 1'b1;
      cyc();
    end
    set_req(p, 1'b0, 1'b0, 16'h0);
    chk("req_accept_timeout", done, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    cyc();
    check_en = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_count", count, 9'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);

    // Push from each port, then pop returns the last value pushed.
    req(0, 1'b0, 16'h1111);
    chk("t1_count1", count, 9'd1);
    req(1, 1'b0, 16'h2222);
    chk("t1_count2", count, 9'd2);
    req(0, 1'b1, 16'h0);
    chk("t1_rsp0_valid", rsp0_valid, 1'b1);
    chk("t1_rsp0_data", rsp0_data, 16'h2222);
    chk("t1_count3", count, 9'd1);
    cyc();

    // Both ports push every cycle: grants alternate starting with port 0.
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'hA0A0);
    set_req(1, 1'b1, 1'b0, 16'hB1B1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_grant0", req0_ready, (i % 2) == 0);
      chk("t2_grant1", req1_ready, (i % 2) == 1);
      cyc();
    end
    set_req(0, 1'b0, 1'b0, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'h0);
    chk("t2_count", count, 9'd4);

    // Fill to DEPTH, then one more push overflows without touching the stack.
    do_reset();
    for (int i = 0; i < DEPTH; i++) req(0, 1'b0, 16'(i * 7 + 3));
    chk("t3_full_pre", full, 1'b1);
    set_req(0, 1'b1, 1'b0, 16'hBEEF);
    #1;
    chk("t3_ready", req0_ready, 1'b1);
    chk("t3_no_push", stk_push, 1'b0);
    cyc();
    set_req(0, 1'b0, 1'b0, 16'h0);
    chk("t3_ovf", err_overflow, 1'b1);
    chk("t3_full", full, 1'b1);
    chk("t3_count", count, 9'd256);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("t3_ovf_clr", err_overflow, 1'b0);

    // Pop on empty from port 1.
    do_reset();
    set_req(1, 1'b1, 1'b1, 16'h0);
    #1;
    chk("t4_no_pop", stk_pop, 1'b0);
    cyc();
    set_req(1, 1'b0, 1'b0, 16'h0);
    chk("t4_rsp1_valid", rsp1_valid, 1'b1);
    chk("t4_rsp1_err", rsp1_err, 1'b1);
    chk("t4_rsp1_data", rsp1_data, 16'h0);
    chk("t4_udf", err_underflow, 1'b1);
    cyc();

    // Flush empties the stack; a later pop underflows.
    do_reset();
    for (int i = 0; i < 3; i++) req(0, 1'b0, 16'h3000 + 16'(i));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t5_count", count, 9'd0);
    req(0, 1'b1, 16'h0);
    chk("t5_rsp_err", rsp0_err, 1'b1);
    cyc();

    // Reset during RESP drops the response.
    do_reset();
    for (int i = 0; i < 5; i++) req(1, 1'b0, 16'h5000 + 16'(i));
    req(0, 1'b1, 16'h0);
    reset = 1'b1;
    #1;
    chk("t6_no_rsp", rsp0_valid, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    chk("t6_count", count, 9'd0);
    chk("t6_empty", empty, 1'b1);
    req(0, 1'b1, 16'h0);
    chk("t6_rsp_err", rsp0_err, 1'b1);
    cyc();

    // Randomized traffic; requesters hold valid/data until accepted.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom % 3) != 0;
        req0_pop   = ($urandom % 5) < 2;
        req0_data  = 16'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom % 3) != 0;
        req1_pop   = ($urandom % 5) < 2;
        req1_data  = 16'($urandom);
      end
      flush   = ($urandom % 60) == 0;
      clr_err = ($urandom % 40) == 0;
      reset   = ($urandom % 700) == 0;
      cyc();
    end
    set_req(0, 1'b0, 1'b0, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'h0);
    flush = 1'b0; clr_err = 1'b0; reset = 1'b0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
